// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider: op codes, FSM states
// and the all-ones constant used for divide-by-zero quotients.
package div_pkg;

   localparam logic [2:0] DIV_OP_DIV  = 3'b100;
   localparam logic [2:0] DIV_OP_DIVU = 3'b101;
   localparam logic [2:0] DIV_OP_REM  = 3'b110;
   localparam logic [2:0] DIV_OP_REMU = 3'b111;

   // Held wider than the default operand width so any WIDTH up to 64 can truncate it.
   localparam logic [63:0] DIV_ALL_ONES = '1;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvsr,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   // The quotient register doubles as the dividend shifter; its MSB feeds the remainder.
   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, i_dvsr};

   always_comb begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
      if (!w_diff[WIDTH]) begin
         o_rem = w_diff[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller with pipeline stall and flush.
// Define DIV_FAST_SPECIAL_EN to skip CALC for zero-divisor and signed-overflow cases.
module div_sequencer
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       div_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic [4:0]       rd_in,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       rd_out
);

   localparam int               CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONES = WIDTH'(DIV_ALL_ONES);
   localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       r_state, w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem, r_quo, r_dvsr, r_dvnd, r_result;
   logic             r_is_rem, r_neg_q, r_neg_r, r_div0, r_ovf;
   logic [4:0]       r_rd, r_rd_out;

   logic             w_load, w_finish, w_from_idle;
   logic             w_in_signed, w_in_is_rem, w_in_neg_a, w_in_neg_b, w_in_div0, w_in_ovf;
   logic [WIDTH-1:0] w_in_a_mag, w_in_b_mag, w_rem_next, w_quo_next, w_fix_result;

   assign w_in_signed = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_REM);
   assign w_in_is_rem = (div_op == DIV_OP_REM) || (div_op == DIV_OP_REMU);
   assign w_in_neg_a  = w_in_signed & dividend[WIDTH-1];
   assign w_in_neg_b  = w_in_signed & divisor[WIDTH-1];
   assign w_in_a_mag  = w_in_neg_a ? -dividend : dividend;
   assign w_in_b_mag  = w_in_neg_b ? -divisor : divisor;
   assign w_in_div0   = (divisor == '0);
   assign w_in_ovf    = w_in_signed && (dividend == MIN) && (divisor == ONES);

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (r_rem),
      .i_quo  (r_quo),
      .i_dvsr (r_dvsr),
      .o_rem  (w_rem_next),
      .o_quo  (w_quo_next)
   );

   function automatic logic [WIDTH-1:0] fix_result(
      input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] dvnd,
      input logic is_rem, input logic neg_q, input logic neg_r, input logic div0, input logic ovf);
      if (div0)        return is_rem ? dvnd : ONES;
      else if (ovf)    return is_rem ? '0 : MIN;
      else if (is_rem) return neg_r ? -r : r;
      else             return neg_q ? -q : q;
   endfunction

   // Finishing straight from IDLE (fast special path) takes flags from the live inputs.
   assign w_from_idle  = (r_state == DIV_IDLE);
   assign w_fix_result = w_from_idle
      ? fix_result('0, '0, dividend, w_in_is_rem, w_in_neg_a ^ w_in_neg_b, w_in_neg_a,
                   w_in_div0, w_in_ovf)
      : fix_result(w_quo_next, w_rem_next, r_dvnd, r_is_rem, r_neg_q, r_neg_r, r_div0, r_ovf);

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         DIV_IDLE: begin
            if (start && !flush) begin
               w_load = 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
               if (w_in_div0 || w_in_ovf) begin
                  w_state_next = DIV_DONE;
                  w_finish     = 1'b1;
               end else begin
                  w_state_next = DIV_CALC;
               end
`else
               w_state_next = DIV_CALC;
`endif
            end
         end
         DIV_CALC: begin
            if (flush) begin
               w_state_next = DIV_IDLE;
            end else if (r_cnt == LAST) begin
               w_state_next = DIV_DONE;
               w_finish     = 1'b1;
            end
         end
         DIV_DONE: w_state_next = DIV_IDLE;
         default:  w_state_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= DIV_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvsr   <= '0;
         r_dvnd   <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_ovf    <= 1'b0;
         r_rd     <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_in_a_mag;
            r_dvsr   <= w_in_b_mag;
            r_dvnd   <= dividend;
            r_is_rem <= w_in_is_rem;
            r_neg_q  <= w_in_neg_a ^ w_in_neg_b;
            r_neg_r  <= w_in_neg_a;
            r_div0   <= w_in_div0;
            r_ovf    <= w_in_ovf;
            r_rd     <= rd_in;
         end else if (r_state == DIV_CALC) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
         end
         // Result is registered on entry to DONE so it is stable for the whole done cycle.
         if (w_finish) begin
            r_result <= w_fix_result;
            r_rd_out <= w_from_idle ? rd_in : r_rd;
         end
      end
   end

   assign busy   = (r_state == DIV_CALC) || (r_state == DIV_DONE);
   assign stall  = ((r_state == DIV_IDLE) && start && !flush) || (r_state == DIV_CALC);
   assign done   = (r_state == DIV_DONE) && !flush && !rst;
   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  div_op = 3'd0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic [4:0]  rd_in = '0;
   logic        flush = 1'b0;
   logic        busy, stall, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int total = 0;
   int bad   = 0;

   div_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .div_op(div_op), .dividend(dividend),
      .divisor(divisor), .rd_in(rd_in), .flush(flush), .busy(busy), .stall(stall),
      .done(done), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic is_rem, sgn;
      logic signed [31:0] sa, sb;
      is_rem = (op == 3'd6) || (op == 3'd7);
      sgn    = (op == 3'd4) || (op == 3'd6);
      sa = a;
      sb = b;
      if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
      if (sgn) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
      return is_rem ? a % b : a / b;
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic sgn, special;
      sgn     = (op == 3'd4) || (op == 3'd6);
      special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
      return special ? 1 : 33;
`else
      return (special) ? 33 : 33;
`endif
   endfunction

   // Called just after a falling edge; returns at the falling edge of the done cycle.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] res,
                         output logic [4:0] rdo);
      start = 1'b1; div_op = op; dividend = a; divisor = b; rd_in = rd;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = result;
      rdo = rd_out;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall); end
      total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got %h want 0", result); end
      total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd got %0d want 0", rd_out); end
      rst = 1'b0;
      $display("reset checked");
   endtask

   task automatic test_divu_timing();
      int cyc, lat;
      logic [31:0] res;
      logic [4:0] rdo;
      @(negedge clk);
      start = 1'b1; div_op = 3'b101; dividend = 32'd100; divisor = 32'd7; rd_in = 5'd5;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL c0_stall got %b want 1", stall); end
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      total++; if ({busy, stall} !== 2'b11) begin bad++; $display("FAIL c1_busy_stall got %b want 11", {busy, stall}); end
      while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      total++; if (cyc !== 33) begin bad++; $display("FAIL divu_lat got %0d want 33", cyc); end
      total++; if (result !== 32'd14) begin bad++; $display("FAIL divu_result got %0d want 14", result); end
      total++; if (rd_out !== 5'd5) begin bad++; $display("FAIL divu_rd got %0d want 5", rd_out); end
      total++; if ({busy, stall} !== 2'b10) begin bad++; $display("FAIL done_busy_stall got %b want 10", {busy, stall}); end
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL idle_after got %b want 00", {busy, done}); end
      total++; if (result !== 32'd14) begin bad++; $display("FAIL result_hold got %0d want 14", result); end
      $display("DIVU 100/7 -> %0d in cycle %0d rd=%0d", result, cyc, rd_out);
      run_op(3'b111, 32'd100, 32'd7, 5'd5, lat, res, rdo);
      total++; if (res !== 32'd2) begin bad++; $display("FAIL remu_result got %0d want 2", res); end
      $display("REMU 100/7 -> %0d lat=%0d", res, lat);
   endtask

   task automatic test_signed_special();
      logic [2:0]  ops [10];
      logic [31:0] as  [10];
      logic [31:0] bs  [10];
      logic [31:0] exp [10];
      int lat;
      logic [31:0] res;
      logic [4:0] rdo;
      ops[0] = 3'b100; as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;          exp[0] = 32'hFFFF_FFFD;
      ops[1] = 3'b110; as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;          exp[1] = 32'hFFFF_FFFF;
      ops[2] = 3'b110; as[2] = 32'd7;         bs[2] = 32'hFFFF_FFFE;  exp[2] = 32'd1;
      ops[3] = 3'b100; as[3] = 32'd5;         bs[3] = 32'd0;          exp[3] = 32'hFFFF_FFFF;
      ops[4] = 3'b110; as[4] = 32'd5;         bs[4] = 32'd0;          exp[4] = 32'd5;
      ops[5] = 3'b100; as[5] = 32'h8000_0000; bs[5] = 32'hFFFF_FFFF;  exp[5] = 32'h8000_0000;
      ops[6] = 3'b110; as[6] = 32'h8000_0000; bs[6] = 32'hFFFF_FFFF;  exp[6] = 32'd0;
      ops[7] = 3'b100; as[7] = 32'hFFFF_FFF0; bs[7] = 32'd0;          exp[7] = 32'hFFFF_FFFF;
      ops[8] = 3'b111; as[8] = 32'h8765_4321; bs[8] = 32'd0;          exp[8] = 32'h8765_4321;
      ops[9] = 3'b100; as[9] = 32'd0;         bs[9] = 32'd9;          exp[9] = 32'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         run_op(ops[i], as[i], bs[i], 5'(i + 10), lat, res, rdo);
         total++; if (res !== exp[i]) begin bad++; $display("FAIL case%0d_result got %h want %h", i, res, exp[i]); end
         total++; if (lat !== exp_lat(ops[i], as[i], bs[i])) begin bad++; $display("FAIL case%0d_lat got %0d want %0d", i, lat, exp_lat(ops[i], as[i], bs[i])); end
         $display("op=%b a=%h b=%h -> %h lat=%0d", ops[i], as[i], bs[i], res, lat);
      end
   endtask

   task automatic test_flush();
      int ndone = 0, lat;
      logic [31:0] res;
      logic [4:0] rdo;
      @(negedge clk);
      start = 1'b1; div_op = 3'b101; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd9;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 10) flush = 1'b1;
         #1;
         if (done === 1'b1) ndone++;
      end
      @(negedge clk);
      flush = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got %b want 0", busy); end
      total++; if (ndone !== 0) begin bad++; $display("FAIL flush_done got %0d want 0", ndone); end
      run_op(3'b101, 32'd9, 32'd3, 5'd3, lat, res, rdo);
      total++; if (res !== 32'd3) begin bad++; $display("FAIL after_flush_result got %0d want 3", res); end
      total++; if (lat + 11 !== 44) begin bad++; $display("FAIL after_flush_cycle got %0d want 44", lat + 11); end
      $display("flush at cycle 10, then DIVU 9/3 -> %0d at cycle %0d", res, lat + 11);
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      logic [31:0] seen = '0;
      @(negedge clk);
      start = 1'b1; div_op = 3'b100; dividend = 32'hFFFF_FF9C; divisor = 32'd7; rd_in = 5'd21;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         start = (c == 5);
         if (c == 5) begin div_op = 3'b101; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd2; end
         #1;
         if (done === 1'b1) begin ndone++; seen = result; end
      end
      start = 1'b0;
      total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_count got %0d want 1", ndone); end
      total++; if (seen !== ref_result(3'b100, 32'hFFFF_FF9C, 32'd7)) begin bad++; $display("FAIL ignore_result got %h want %h", seen, ref_result(3'b100, 32'hFFFF_FF9C, 32'd7)); end
      $display("start during CALC ignored: dones=%0d result=%h", ndone, seen);
   endtask

   task automatic test_rst_mid();
      int lat;
      logic [31:0] res;
      logic [4:0] rdo;
      @(negedge clk);
      run_op(3'b101, 32'd50, 32'd5, 5'd17, lat, res, rdo);
      total++; if (res !== 32'd10) begin bad++; $display("FAIL pre_rst_result got %0d want 10", res); end
      @(negedge clk);
      start = 1'b1; div_op = 3'b101; dividend = 32'd77; divisor = 32'd5; rd_in = 5'd17;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      total++; if ({busy, done, stall} !== 3'b000) begin bad++; $display("FAIL rst_mid_ctrl got %b want 000", {busy, done, stall}); end
      total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_mid_result got %h want 0", result); end
      total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL rst_mid_rd got %0d want 0", rd_out); end
      rst = 1'b0;
      $display("reset during CALC cycle 20 cleared outputs");
   endtask

   task automatic test_flush_start();
      int ndone = 0;
      @(negedge clk);
      start = 1'b1; flush = 1'b1; div_op = 3'b101; dividend = 32'd40; divisor = 32'd4; rd_in = 5'd8;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fs_stall got %b want 0", stall); end
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL fs_busy got %b want 0", busy); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      total++; if (ndone !== 0) begin bad++; $display("FAIL fs_done got %0d want 0", ndone); end
      $display("flush with start in IDLE dropped the request");
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic [31:0] a, b, exp;
      logic [4:0]  rd;
      int lat;
      logic [31:0] res;
      logic [4:0] rdo;
      @(negedge clk);
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         rd  = 5'($urandom_range(0, 31));
         exp = ref_result(op, a, b);
         if (i > 0) begin
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d got %b want 0", i, busy); end
         end
         run_op(op, a, b, rd, lat, res, rdo);
         total++; if (res !== exp) begin bad++; $display("FAIL rand%0d_result got %h want %h", i, res, exp); end
         total++; if (rdo !== rd) begin bad++; $display("FAIL rand%0d_rd got %0d want %0d", i, rdo, rd); end
         total++; if (lat !== exp_lat(op, a, b)) begin bad++; $display("FAIL rand%0d_lat got %0d want %0d", i, lat, exp_lat(op, a, b)); end
         $display("rand%0d op=%b a=%h b=%h -> %h rd=%0d lat=%0d", i, op, a, b, res, rdo, lat);
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_divu_timing();
      test_signed_special();
      test_flush();
      test_ignore_start();
      test_rst_mid();
      test_flush_start();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
